// File: rtl/csa11_accum.sv
//==============================================================================
// Module      : csa11_accum
// Description : Sequential accumulation stage around an 11-bit carry-select
//               adder. Takes NUM_OPS unsigned 11-bit operands over a
//               valid/ready handshake, folds each into an accumulator through
//               a single CSA11 (accumulator on the feedback path) and presents
//               the sum plus a sticky carry-out flag on a valid/ready result
//               port.
//
// Ports       : clk        in   1   rising-edge clock
//               rst_n      in   1   synchronous active-low reset
//               start      in   1   begin a transaction (sampled in IDLE only)
//               op_valid   in   1   operand valid
//               op_data    in  11   operand, unsigned
//               op_ready   out  1   operand accepted this cycle
//               res_valid  out  1   result available
//               res_ready  in   1   downstream accepts result
//               res_sum    out 11   accumulated sum
//               res_ovf    out  1   sticky: some addition produced a carry-out
//               busy       out  1   high in ACCUM and DONE
//
// Config      : `define CSA11_ACCUM_SATURATE_EN to clamp the accumulator at
//               0x7FF on carry-out instead of wrapping modulo 2048.
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

//------------------------------------------------------------------------------
// csa11_rca : W-bit ripple-carry segment used as a building block of CSA11.
//------------------------------------------------------------------------------
module csa11_rca #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);

    logic [W:0] w_c;

    assign w_c[0] = c_i;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_fa
            assign s_o[gi]   = a_i[gi] ^ b_i[gi] ^ w_c[gi];
            assign w_c[gi+1] = (a_i[gi] & b_i[gi]) | (w_c[gi] & (a_i[gi] ^ b_i[gi]));
        end
    endgenerate

    assign c_o = w_c[W];

endmodule

//------------------------------------------------------------------------------
// csa11 : 11-bit carry-select adder. Low nibble ripples directly; the middle
// nibble and top 3 bits are each computed for both carry-in values and the
// real carry picks the right copy.
//------------------------------------------------------------------------------
module csa11 (
    input  logic [10:0] a11,
    input  logic [10:0] b11,
    input  logic        in11,
    output logic [10:0] s11,
    output logic        co11
);

    logic [3:0] w_s_lo;
    logic       w_c_lo;
    logic [3:0] w_s_mid0, w_s_mid1;
    logic       w_c_mid0, w_c_mid1;
    logic [2:0] w_s_hi0, w_s_hi1;
    logic       w_c_hi0, w_c_hi1;
    logic       w_c_mid;

    csa11_rca #(.W(4)) u_lo (
        .a_i(a11[3:0]), .b_i(b11[3:0]), .c_i(in11),
        .s_o(w_s_lo),   .c_o(w_c_lo)
    );

    csa11_rca #(.W(4)) u_mid0 (
        .a_i(a11[7:4]), .b_i(b11[7:4]), .c_i(1'b0),
        .s_o(w_s_mid0), .c_o(w_c_mid0)
    );

    csa11_rca #(.W(4)) u_mid1 (
        .a_i(a11[7:4]), .b_i(b11[7:4]), .c_i(1'b1),
        .s_o(w_s_mid1), .c_o(w_c_mid1)
    );

    csa11_rca #(.W(3)) u_hi0 (
        .a_i(a11[10:8]), .b_i(b11[10:8]), .c_i(1'b0),
        .s_o(w_s_hi0),   .c_o(w_c_hi0)
    );

    csa11_rca #(.W(3)) u_hi1 (
        .a_i(a11[10:8]), .b_i(b11[10:8]), .c_i(1'b1),
        .s_o(w_s_hi1),   .c_o(w_c_hi1)
    );

    assign w_c_mid = w_c_lo ? w_c_mid1 : w_c_mid0;

    assign s11[3:0]  = w_s_lo;
    assign s11[7:4]  = w_c_lo  ? w_s_mid1 : w_s_mid0;
    assign s11[10:8] = w_c_mid ? w_s_hi1  : w_s_hi0;
    assign co11      = w_c_mid ? w_c_hi1  : w_c_hi0;

endmodule

//------------------------------------------------------------------------------
// csa11_accum : top level
//------------------------------------------------------------------------------
module csa11_accum #(
    parameter int NUM_OPS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_valid,
    input  logic [10:0] op_data,
    output logic        op_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [10:0] res_sum,
    output logic        res_ovf,
    output logic        busy
);

    localparam logic [7:0]  C_LAST_CNT = 8'(NUM_OPS - 1);
    localparam logic [10:0] C_ACC_MAX  = 11'h7FF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [10:0] acc_q;
    logic [10:0] acc_d;
    logic        ovf_q;
    logic [7:0]  cnt_q;
    logic        op_ready_q;
    logic        res_valid_q;
    logic        busy_q;

    logic [10:0] w_s11;
    logic        w_co11;
    logic        w_accept;

    // Adder sits on the accumulator feedback path; its outputs only reach
    // the ports through acc_q/ovf_q.
    csa11 u_csa11 (
        .a11  (acc_q),
        .b11  (op_data),
        .in11 (1'b0),
        .s11  (w_s11),
        .co11 (w_co11)
    );

    // op_ready_q is high exactly when the state is ACCUM.
    assign w_accept = op_valid & op_ready_q;

    always_comb begin
        acc_d = w_s11;
`ifdef CSA11_ACCUM_SATURATE_EN
        // Clamp on carry-out. A saturated accumulator stays at max because
        // any non-zero operand carries out again and zero leaves it alone.
        if (w_co11) begin
            acc_d = C_ACC_MAX;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q      <= '0;
                        ovf_q      <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_ACCUM;
                        op_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end

                S_ACCUM: begin
                    if (w_accept) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_q | w_co11;
                        if (cnt_q == C_LAST_CNT) begin
                            // Wrap the counter here so it never exceeds
                            // NUM_OPS-1.
                            cnt_q       <= '0;
                            state_q     <= S_DONE;
                            op_ready_q  <= 1'b0;
                            res_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end

                S_DONE: begin
                    if (res_ready) begin
                        state_q     <= S_IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    op_ready_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready  = op_ready_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign res_sum   = acc_q;
    assign res_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: doc/csa11_accum.md
Name: csa11_accum

Overview:
- Sequential accumulation stage wrapped around the 11-bit carry-select adder (CSA11).
- Accepts a stream of NUM_OPS 11-bit operands over a valid/ready handshake.
- Folds each operand into an internal accumulator through one CSA11 instance, with the accumulator on the feedback path.
- Presents the final sum plus a sticky overflow flag on a valid/ready result port to the downstream consumer.

Parameters:
- NUM_OPS, 4, operands summed per transaction; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  begins a transaction; sampled only in IDLE.
- op_valid  input  1  operand on op_data is valid.
- op_data  input  11  operand, unsigned.
- op_ready  output  1  block accepts operand this cycle.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts result.
- res_sum  output  11  accumulated sum (mod 2^11, or saturated; see Optional Feature).
- res_ovf  output  1  sticky: some addition in the transaction produced a CSA11 carry-out.
- busy  output  1  high in ACCUM and DONE.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous, active-low (rst_n).
  - All state updates on the rising edge of clk.
- Values held while rst_n=0 and on the first edge after:
  - state=IDLE, acc=0, ovf=0, cnt=0.
  - op_ready=0, res_valid=0, res_sum=0, res_ovf=0, busy=0.
- Adder instance:
  - One CSA11, driven with a11=acc, b11=op_data, in11=0.
  - Its s11 and co11 are registered; there is no combinational path from op_data to any output.
- State machine, states IDLE, ACCUM, DONE:
  - IDLE:
    - op_ready=0, res_valid=0.
    - start=1 → acc<=0, ovf<=0, cnt<=0, go to ACCUM.
  - ACCUM:
    - op_ready=1.
    - On op_valid&op_ready: acc<=s11, ovf<=ovf|co11, cnt<=cnt+1.
    - If this beat is operand NUM_OPS (cnt==NUM_OPS-1), go to DONE.
    - op_valid=0 → hold all state; no timeout.
  - DONE:
    - op_ready=0, res_valid=1.
    - res_sum and res_ovf are driven from registers and held stable until the handshake.
    - res_valid&res_ready → go to IDLE; res_valid falls on the next edge.
    - No handshake → hold indefinitely.
- Outputs are decoded from the registered state only:
  - op_ready = (state==ACCUM).
  - res_valid = (state==DONE).
  - busy = (state!=IDLE).
- Latency: res_valid rises exactly 1 cycle after the edge that accepts the final operand.
- Throughput:
  - 1 operand per cycle in ACCUM.
  - Minimum transaction = NUM_OPS + 2 cycles: start cycle, operand beats, DONE cycle.
  - Back-to-back transactions require one IDLE cycle.
- Counter: cnt is 8 bits and never exceeds NUM_OPS-1.
- Boundary conditions:
  - start outside IDLE: ignored, no effect.
  - start in the same cycle as the DONE handshake: ignored, because the block is still in DONE. start must be reasserted in IDLE.
  - NUM_OPS=1: a single accepted operand goes to DONE with res_sum=op_data and res_ovf=0.
  - Carry wrap without the optional feature: acc wraps mod 2048 and ovf sets sticky. Example: 0x7FF+0x001 gives res_sum=0x000, res_ovf=1.
  - Reset mid-transaction: the partial sum is discarded, state returns to IDLE, and all outputs take their reset values on that edge.

Optional Feature:
- Macro: CSA11_ACCUM_SATURATE_EN.
- Defined:
  - When co11=1 on an accepted beat, acc<=0x7FF instead of s11, and ovf sets.
  - Once saturated, acc stays 0x7FF for the rest of the transaction.
  - The CSA11 carry-out still drives ovf.
- Undefined: modular wrap as described in Behaviour; no saturation logic is synthesized.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles while driving start=1 and op_valid=1 → op_ready=0, res_valid=0, res_sum=0, busy=0 throughout and on the first edge after release.
2. Basic sum, NUM_OPS=4:
   - Stimulus: start, then operands 0x010, 0x020, 0x030, 0x040 on consecutive cycles.
   - Response: res_valid 1 cycle after the 4th beat, res_sum=0x0A0, res_ovf=0.
   - With res_ready=1, res_valid falls the next cycle and state returns to IDLE.
3. Bubbles and backpressure:
   - Stimulus: same operands with op_valid low for 2 cycles between beats; hold res_ready=0 for 5 cycles.
   - Response: res_sum=0x0A0 held stable with res_valid=1 for all 5 cycles; exactly 4 beats accepted.
4. Overflow:
   - Stimulus: operands 0x7FF, 0x001, 0x000, 0x000.
   - Response without the macro: res_sum=0x000, res_ovf=1.
   - Response with CSA11_ACCUM_SATURATE_EN: res_sum=0x7FF, res_ovf=1.
5. Illegal start: pulse start during ACCUM and during the DONE handshake cycle → no restart, result unchanged, block sits in IDLE afterwards.
6. Mid-operation reset: rst_n=0 for 1 cycle after 2 accepted operands, then a fresh transaction of 0x001×4 → res_sum=0x004, res_ovf=0.
